// File: rtl/demux_pkg.sv
// Shared definitions for the burst-scheduled 1:4 demultiplexer.
//   state_t        : scheduler FSM encoding
//   NUM_CH, SEL_W  : channel count and channel-select width
//   onehot()       : channel select to one-hot valid vector
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_burst_sched_demux.sv
// 1:4 demultiplexer: steers a single valid bit onto the selected channel.
//   in   : valid to route
//   sel  : destination channel
//   out  : one-hot valid per channel (all zero when in=0)
module demux_burst_sched_demux
    import demux_pkg::*;
(
    input  logic              in,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] out
);

    assign out = in ? onehot(sel) : '0;

endmodule

// File: rtl/demux_burst_sched.sv
// Burst scheduler and flow controller in front of the 1:4 demux.
// Routes a valid/ready beat stream to one of four channels in bursts of
// BURST_LEN beats, either rotating round-robin or to a software-chosen
// channel, through one registered output stage with per-channel backpressure.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : allows bursts to start and beats to be accepted
//   mode        : 0 = round-robin, 1 = fixed channel (fixed_sel)
//   fixed_sel   : target channel in fixed mode, sampled at burst start
//   in_valid/in_data/in_ready : input stream
//   out_valid   : one-hot channel holding a beat
//   out_data    : held beat, shared by all channels
//   out_ready   : per-channel consumer ready
//   cur_sel     : channel for the current or next burst
//   busy        : FSM not idle or a beat is held
//   beat_cnt    : per-channel drained-beat counters, saturating
//                 (only when DEMUX_BURST_SCHED_STATS_EN is defined)
module demux_burst_sched
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        fixed_sel,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    busy
`ifdef DEMUX_BURST_SCHED_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] beat_cnt
`endif
);

    localparam int unsigned BCNT_W = $clog2(BURST_LEN + 1);

    // Elaboration-time parameter sanity check.
    if (BURST_LEN < 1 || CNT_W < 1) begin : g_bad_param
        $error("demux_burst_sched: BURST_LEN and CNT_W must be >= 1");
    end

    state_t            state;
    logic [BCNT_W-1:0] beats_q;
    logic              burst_mode_q;
    logic              hold_full;
    logic [SEL_W-1:0]  hold_sel;
    logic              accept;
    logic              drain;
    logic              last_beat;

    // The held beat only waits on its own channel, never on cur_sel.
    assign drain     = hold_full && out_ready[hold_sel];
    // Beats are only taken inside a burst, so a burst boundary costs one IDLE cycle.
    assign in_ready  = !rst && enable && (state == ROUTE) && (!hold_full || out_ready[hold_sel]);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beats_q == BCNT_W'(BURST_LEN - 1));
    assign busy      = (state != IDLE) || hold_full;

    // Burst sequencing: channel choice, beat counting, enable-drop drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_sel      <= '0;
            beats_q      <= '0;
            burst_mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= ROUTE;
                        // Mode is latched so a mid-burst change waits for the next burst.
                        burst_mode_q <= mode;
                        if (mode) begin
                            cur_sel <= fixed_sel;
                        end
                    end
                end
                ROUTE: begin
                    if (accept) begin
                        if (last_beat) begin
                            beats_q <= '0;
                            state   <= IDLE;
                            if (!burst_mode_q) begin
                                cur_sel <= cur_sel + SEL_W'(1);
                            end
                        end else begin
                            beats_q <= beats_q + BCNT_W'(1);
                        end
                    end else if (!enable) begin
                        // Nothing to abandon on an empty burst; go straight back to IDLE.
                        state <= (beats_q != '0) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    // Partial burst is abandoned; cur_sel deliberately not advanced.
                    if (!hold_full) begin
                        beats_q <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output holding register; a same-cycle drain and accept reloads with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_sel  <= '0;
            out_data  <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_sel  <= cur_sel;
            out_data  <= in_data;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    demux_burst_sched_demux u_demux (
        .in  (hold_full),
        .sel (hold_sel),
        .out (out_valid)
    );

`ifdef DEMUX_BURST_SCHED_STATS_EN
    logic [NUM_CH*CNT_W-1:0] stats_q;

    // Per-channel drained-beat counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stats_q <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (out_valid[k] && out_ready[k] && (stats_q[k*CNT_W +: CNT_W] != '1)) begin
                    stats_q[k*CNT_W +: CNT_W] <= stats_q[k*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign beat_cnt = stats_q;
`endif

endmodule

// File: tb/tb_demux_burst_sched.sv
// Directed self-checking bench for demux_burst_sched (BURST_LEN=4, DATA_W=8).
// Exercises beat counters when built with DEMUX_BURST_SCHED_STATS_EN.
module tb_demux_burst_sched;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              mode;
    logic [1:0]        fixed_sel;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_ready;
    logic [1:0]        cur_sel;
    logic              busy;
`ifdef DEMUX_BURST_SCHED_STATS_EN
    logic [4*CNT_W-1:0] beat_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic [1:0] exp_ch[$];

    demux_burst_sched #(
        .DATA_W    (DATA_W),
        .BURST_LEN (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .fixed_sel (fixed_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cur_sel   (cur_sel),
        .busy      (busy)
`ifdef DEMUX_BURST_SCHED_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n beats d0, d0+1, ...; each accepted beat is checked against exp_ch.
    task automatic send(input int n, input logic [DATA_W-1:0] d0, output int cycles);
        int         sent;
        logic       took;
        logic [1:0] ch;
        sent     = 0;
        cycles   = 0;
        in_valid = 1'b1;
        in_data  = d0;
        while (sent < n && cycles < 200) begin
            #1;
            took = in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (took) begin
                ch = exp_ch.pop_front();
                check("beat_valid", 32'(out_valid), 32'(4'b0001 << ch));
                check("beat_data", 32'(out_data), 32'(in_data));
                sent++;
                in_data = d0 + DATA_W'(sent);
            end
        end
        in_valid = 1'b0;
        check("beat_count", 32'(sent), 32'(n));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; fixed_sel = 2'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 4'b0000;

        // Reset state
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_cur_sel", 32'(cur_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Round-robin: 16 beats, 4 per channel, one idle cycle per burst
        enable = 1'b1; mode = 1'b0; out_ready = 4'b1111;
        for (int i = 0; i < 16; i++) exp_ch.push_back(2'(i / 4));
        send(16, 8'h00, cyc);
        check("rr_cycles", 32'(cyc), 32'd20);
        check("rr_wrap_sel", 32'(cur_sel), 32'd0);
        enable = 1'b0;
        step();
        step();
        check("rr_idle_busy", 32'(busy), 32'd0);
        check("rr_idle_valid", 32'(out_valid), 32'd0);

        // Fixed channel 2 for two bursts
        mode = 1'b1; fixed_sel = 2'd2; enable = 1'b1;
        for (int i = 0; i < 8; i++) exp_ch.push_back(2'd2);
        send(8, 8'h20, cyc);
        check("fix_sel2", 32'(cur_sel), 32'd2);

        // fixed_sel change after beat 2 applies from beat 4
        for (int i = 0; i < 3; i++) exp_ch.push_back(2'd2);
        send(3, 8'h30, cyc);
        fixed_sel = 2'd1;
        exp_ch.push_back(2'd2);
        for (int i = 0; i < 4; i++) exp_ch.push_back(2'd1);
        send(5, 8'h33, cyc);
        check("fix_sel1", 32'(cur_sel), 32'd1);

        // Backpressure on ch0 with 0xA5 held
        enable = 1'b0;
        step();
        step();
        fixed_sel = 2'd0; out_ready = 4'b1110; enable = 1'b1;
        exp_ch.push_back(2'd0);
        send(1, 8'hA5, cyc);
        in_valid = 1'b1; in_data = 8'hA6;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'b0001);
            check("bp_data", 32'(out_data), 32'hA5);
            check("bp_in_ready_hold", 32'(in_ready), 32'd0);
        end
        out_ready = 4'b1111;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_reload_valid", 32'(out_valid), 32'b0001);
        check("bp_reload_data", 32'(out_data), 32'hA6);
        in_valid = 1'b0;
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Cross-burst hold: last ch0 beat stalls, next burst is ch1
        fixed_sel = 2'd1;
        exp_ch.push_back(2'd0);
        exp_ch.push_back(2'd0);
        send(2, 8'hB0, cyc);
        out_ready = 4'b1110;
        check("xb_last_valid", 32'(out_valid), 32'b0001);
        step();
        check("xb_new_sel", 32'(cur_sel), 32'd1);
        in_valid = 1'b1; in_data = 8'hC0;
        #1;
        check("xb_blocked", 32'(in_ready), 32'd0);
        step();
        check("xb_blocked2", 32'(in_ready), 32'd0);
        check("xb_held_valid", 32'(out_valid), 32'b0001);
        check("xb_held_data", 32'(out_data), 32'hB1);
        out_ready = 4'b0010;
        #1;
        check("xb_ch1_only", 32'(in_ready), 32'd0);
        out_ready = 4'b0011;
        #1;
        check("xb_ch0_ready", 32'(in_ready), 32'd1);
        step();
        check("xb_c0_valid", 32'(out_valid), 32'b0010);
        check("xb_c0_data", 32'(out_data), 32'hC0);
        in_valid = 1'b0;

        // Enable drop after 2 beats: DRAIN, then IDLE, cur_sel kept
        exp_ch.push_back(2'd1);
        send(1, 8'hC1, cyc);
        enable = 1'b0; out_ready = 4'b0000;
        #1;
        check("ed_in_ready", 32'(in_ready), 32'd0);
        step();
        check("ed_busy1", 32'(busy), 32'd1);
        check("ed_valid1", 32'(out_valid), 32'b0010);
        check("ed_data1", 32'(out_data), 32'hC1);
        step();
        check("ed_busy2", 32'(busy), 32'd1);
        out_ready = 4'b0010;
        step();
        check("ed_drained", 32'(out_valid), 32'd0);
        check("ed_still_drain", 32'(busy), 32'd1);
        step();
        check("ed_idle", 32'(busy), 32'd0);
        check("ed_sel_kept", 32'(cur_sel), 32'd1);
        mode = 1'b0; out_ready = 4'b1111; enable = 1'b1;
        for (int i = 0; i < 4; i++) exp_ch.push_back(2'd1);
        exp_ch.push_back(2'd2);
        send(5, 8'hD0, cyc);
        check("ed_full_burst_sel", 32'(cur_sel), 32'd2);

        // Reset mid-burst with a beat held on ch2
        check("mr_held", 32'(out_valid), 32'b0100);
        rst = 1'b1; in_valid = 1'b1;
        #1;
        check("mr_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0; enable = 1'b0; in_valid = 1'b0;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_cur_sel", 32'(cur_sel), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_data", 32'(out_data), 32'd0);
`ifdef DEMUX_BURST_SCHED_STATS_EN
        check("st_clear", 32'(beat_cnt), 32'd0);
`endif
        step();

        // Second 16-beat round-robin run from reset
        enable = 1'b1; mode = 1'b0; out_ready = 4'b1111;
        for (int i = 0; i < 16; i++) exp_ch.push_back(2'(i / 4));
        send(16, 8'h40, cyc);
        check("rr2_cycles", 32'(cyc), 32'd20);
        enable = 1'b0;
        step();
        step();
        check("rr2_busy", 32'(busy), 32'd0);
`ifdef DEMUX_BURST_SCHED_STATS_EN
        check("st_counts", 32'(beat_cnt), 32'h04040404);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
